ethernet_header_inserter_deadlock_reporter: RTL and testbench

- Consumes the 1-bit deadlock `block` output of the ethernet header inserter's top-level dataflow deadlock monitor.
- Debounces it: `block` must be high for THRESHOLD consecutive cycles before a deadlock is declared.
- On declaration: captures a snapshot of the per-process idle/block vectors with a timestamp, raises a sticky flag plus a one-cycle interrupt, and keeps event, glitch and lock-duration statistics for host readout.

---
 rtl/ethernet_header_inserter_deadlock_reporter.sv | 139 +++++++++++++
 tb/tb_ethernet_header_inserter_deadlock_reporter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_header_inserter_deadlock_reporter.sv
// Debounces the dataflow deadlock monitor's block output and records a
// timestamped snapshot of the idle/block vectors plus event statistics.
module ethernet_header_inserter_deadlock_reporter #(
  parameter int unsigned THRESHOLD = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned DUR_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             block,
  input  logic [3:0]       axis_block_sigs,
  input  logic [6:0]       inst_idle_sigs,
  input  logic [3:0]       inst_block_sigs,
  input  logic             clear,
  output logic             deadlock_irq,
  output logic             deadlock_flag,
  output logic             deadlock_active,
  output logic [3:0]       snap_axis_block,
  output logic [6:0]       snap_inst_idle,
  output logic [3:0]       snap_inst_block,
  output logic [TS_W-1:0]  snap_timestamp,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] glitch_count,
  output logic [DUR_W-1:0] lock_duration
);

  localparam int RUN_W = $clog2(THRESHOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [TS_W-1:0]  ts_q;
  logic             declare, glitch, capture;
  logic [CNT_W-1:0] ev_base, ev_d, gl_base, gl_d;
  logic [DUR_W-1:0] dur_d;

  assign run_inc = run_q + 1'b1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    declare = 1'b0;
    glitch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (block) begin
          if (THRESHOLD == 1) begin
            declare = 1'b1;
            state_d = LOCKED;
            run_d   = RUN_W'(THRESHOLD);
          end else begin
            state_d = PENDING;
            run_d   = RUN_W'(1);
          end
        end
      end
      PENDING: begin
        if (block) begin
          run_d = run_inc;
          if (run_inc == RUN_W'(THRESHOLD)) begin
            declare = 1'b1;
            state_d = LOCKED;
          end
        end else begin
          glitch  = 1'b1;
          state_d = IDLE;
          run_d   = '0;
        end
      end
      LOCKED: begin
        if (!block) begin
          state_d = IDLE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  // clear resolves before a same-edge declaration or glitch
  always_comb begin
    ev_base = clear ? '0 : event_count;
    gl_base = clear ? '0 : glitch_count;
    ev_d    = ev_base;
    gl_d    = gl_base;
    if (declare && ev_base != '1) ev_d = ev_base + 1'b1;
    if (glitch && gl_base != '1)  gl_d = gl_base + 1'b1;
    capture = declare && (!deadlock_flag || clear);
    dur_d   = lock_duration;
    if (declare)
      dur_d = DUR_W'(1);
    else if (state_q == LOCKED && block && lock_duration != '1)
      dur_d = lock_duration + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      run_q           <= '0;
      ts_q            <= '0;
      deadlock_irq    <= 1'b0;
      deadlock_flag   <= 1'b0;
      deadlock_active <= 1'b0;
      snap_axis_block <= '0;
      snap_inst_idle  <= '0;
      snap_inst_block <= '0;
      snap_timestamp  <= '0;
      event_count     <= '0;
      glitch_count    <= '0;
      lock_duration   <= '0;
    end else begin
      state_q         <= state_d;
      run_q           <= run_d;
      ts_q            <= ts_q + 1'b1;
      deadlock_irq    <= declare;
      deadlock_flag   <= declare | (deadlock_flag & ~clear);
      deadlock_active <= (state_d == LOCKED);
      event_count     <= ev_d;
      glitch_count    <= gl_d;
      lock_duration   <= dur_d;
      if (capture) begin
        snap_axis_block <= axis_block_sigs;
        snap_inst_idle  <= inst_idle_sigs;
        snap_inst_block <= inst_block_sigs;
        snap_timestamp  <= ts_q;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_header_inserter_deadlock_reporter.sv
// Directed bench for the deadlock reporter (THRESHOLD=4, CNT_W=2).
module tb_ethernet_header_inserter_deadlock_reporter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        block = 1'b0;
  logic [3:0]  axis_block_sigs = '0;
  logic [6:0]  inst_idle_sigs = '0;
  logic [3:0]  inst_block_sigs = '0;
  logic        clear = 1'b0;
  logic        deadlock_irq, deadlock_flag, deadlock_active;
  logic [3:0]  snap_axis_block, snap_inst_block;
  logic [6:0]  snap_inst_idle;
  logic [31:0] snap_timestamp;
  logic [1:0]  event_count, glitch_count;
  logic [15:0] lock_duration;

  int total = 0;
  int bad = 0;
  int unsigned edges;
  int unsigned exp_ts;

  ethernet_header_inserter_deadlock_reporter #(
    .THRESHOLD(4), .CNT_W(2), .TS_W(32), .DUR_W(16)
  ) dut (
    .clock(clock), .reset(reset), .block(block),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .clear(clear),
    .deadlock_irq(deadlock_irq),
    .deadlock_flag(deadlock_flag),
    .deadlock_active(deadlock_active),
    .snap_axis_block(snap_axis_block),
    .snap_inst_idle(snap_inst_idle),
    .snap_inst_block(snap_inst_block),
    .snap_timestamp(snap_timestamp),
    .event_count(event_count),
    .glitch_count(glitch_count),
    .lock_duration(lock_duration)
  );

  always #5 clock = ~clock;

  // reference timestamp: edges seen since reset release
  always @(posedge clock or posedge reset)
    if (reset) edges <= 0;
    else edges <= edges + 1;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic check_snap(input string tag, input logic [3:0] a,
                            input logic [6:0] id, input logic [3:0] b,
                            input logic [31:0] ts);
    check({tag, "_axis"}, 64'(snap_axis_block), 64'(a));
    check({tag, "_idle"}, 64'(snap_inst_idle), 64'(id));
    check({tag, "_iblk"}, 64'(snap_inst_block), 64'(b));
    check({tag, "_ts"}, 64'(snap_timestamp), 64'(ts));
  endtask

  initial begin
    @(negedge clock);
    check("rst_flag", 64'(deadlock_flag), 64'd0);
    check("rst_irq", 64'(deadlock_irq), 64'd0);
    check("rst_dur", 64'(lock_duration), 64'd0);
    reset = 1'b0;

    // 1: short run aborts as a glitch
    block = 1'b1;
    step(3);
    check("t1_pending_active", 64'(deadlock_active), 64'd0);
    block = 1'b0;
    step();
    check("t1_irq", 64'(deadlock_irq), 64'd0);
    check("t1_flag", 64'(deadlock_flag), 64'd0);
    check("t1_glitch", 64'(glitch_count), 64'd1);
    check("t1_active", 64'(deadlock_active), 64'd0);

    // 2: declaration with timestamp 100 at the 4th edge
    for (int g = 0; g < 200 && edges != 97; g++) step();
    check("t2_align", 64'(edges), 64'd97);
    axis_block_sigs = 4'b0001;
    inst_idle_sigs  = 7'h05;
    inst_block_sigs = 4'b1010;
    block = 1'b1;
    step(3);
    check("t2_irq_early", 64'(deadlock_irq), 64'd0);
    step();
    check("t2_irq", 64'(deadlock_irq), 64'd1);
    check("t2_flag", 64'(deadlock_flag), 64'd1);
    check("t2_events", 64'(event_count), 64'd1);
    check("t2_active", 64'(deadlock_active), 64'd1);
    check("t2_dur", 64'(lock_duration), 64'd1);
    check_snap("t2_snap", 4'h1, 7'h05, 4'hA, 32'd100);
    axis_block_sigs = 4'hF;
    inst_idle_sigs  = 7'h7F;
    inst_block_sigs = 4'hF;
    step();
    check("t2_irq_pulse", 64'(deadlock_irq), 64'd0);

    // 3: 14 high samples total, then low
    step(9);
    check("t3_dur", 64'(lock_duration), 64'd11);
    check("t3_active_hi", 64'(deadlock_active), 64'd1);
    block = 1'b0;
    step();
    check("t3_active_lo", 64'(deadlock_active), 64'd0);
    step();
    check("t3_dur_hold", 64'(lock_duration), 64'd11);
    check_snap("t3_snap", 4'h1, 7'h05, 4'hA, 32'd100);

    // 4: second event without clear, then clear
    axis_block_sigs = 4'hC;
    inst_idle_sigs  = 7'h3A;
    inst_block_sigs = 4'h5;
    block = 1'b1;
    step(4);
    check("t4_irq", 64'(deadlock_irq), 64'd1);
    check("t4_events", 64'(event_count), 64'd2);
    check("t4_dur", 64'(lock_duration), 64'd1);
    check_snap("t4_snap", 4'h1, 7'h05, 4'hA, 32'd100);
    block = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t4_clr_flag", 64'(deadlock_flag), 64'd0);
    check("t4_clr_events", 64'(event_count), 64'd0);
    check("t4_clr_glitch", 64'(glitch_count), 64'd0);
    check("t4_clr_dur", 64'(lock_duration), 64'd1);
    check_snap("t4_clr_snap", 4'h1, 7'h05, 4'hA, 32'd100);

    // 5: clear coinciding with declaration, then glitch saturation
    block = 1'b1;
    step(3);
    axis_block_sigs = 4'h3;
    inst_idle_sigs  = 7'h11;
    inst_block_sigs = 4'h6;
    clear = 1'b1;
    exp_ts = edges;
    step();
    clear = 1'b0;
    check("t5_flag", 64'(deadlock_flag), 64'd1);
    check("t5_events", 64'(event_count), 64'd1);
    check_snap("t5_snap", 4'h3, 7'h11, 4'h6, exp_ts);
    block = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      block = 1'b1;
      step();
      block = 1'b0;
      step();
    end
    check("t5_glitch_sat", 64'(glitch_count), 64'd3);
    block = 1'b1;
    step();
    block = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_clr_glitch", 64'(glitch_count), 64'd1);
    check("t5_clr_flag", 64'(deadlock_flag), 64'd0);

    // 6: asynchronous reset mid-LOCKED
    block = 1'b1;
    step(4);
    check("t6_locked", 64'(deadlock_active), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_active", 64'(deadlock_active), 64'd0);
    check("t6_rst_flag", 64'(deadlock_flag), 64'd0);
    check("t6_rst_events", 64'(event_count), 64'd0);
    check("t6_rst_glitch", 64'(glitch_count), 64'd0);
    check("t6_rst_dur", 64'(lock_duration), 64'd0);
    check("t6_rst_ts", 64'(snap_timestamp), 64'd0);
    check("t6_rst_axis", 64'(snap_axis_block), 64'd0);
    #1 reset = 1'b0;
    step(3);
    check("t6_irq_early", 64'(deadlock_irq), 64'd0);
    check("t6_active_early", 64'(deadlock_active), 64'd0);
    step();
    check("t6_irq", 64'(deadlock_irq), 64'd1);
    check("t6_flag", 64'(deadlock_flag), 64'd1);
    check("t6_events", 64'(event_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
